// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-clock-enable divider, frame counters,
// sync/DE decode and a one-pixel registered, blanked colour output stage.
module vga_timing_gen #(
    parameter int unsigned H_VIS   = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned V_VIS   = 400,
    parameter int unsigned V_FP    = 12,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 35,
    parameter int unsigned H_POL   = 0,
    parameter int unsigned V_POL   = 1,
    parameter int unsigned PIX_DIV = 2,
    parameter int unsigned CW      = 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [CW-1:0] in_r,
    input  logic [CW-1:0] in_g,
    input  logic [CW-1:0] in_b,
    output logic [10:0]   x,
    output logic [10:0]   y,
    output logic          req,
    output logic          pix_ce,
    output logic          line_start,
    output logic          frame_start,
    output logic [CW-1:0] r,
    output logic [CW-1:0] g,
    output logic [CW-1:0] b,
    output logic          hs,
    output logic          vs,
    output logic          de
);

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned DW    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [10:0]   H_LAST   = 11'(H_TOT - 1);
    localparam logic [10:0]   V_LAST   = 11'(V_TOT - 1);
    // 12-bit bounds so a sync interval ending exactly at 2048 still decodes
    localparam logic [11:0]   HS_BEG   = 12'(H_VIS + H_FP);
    localparam logic [11:0]   HS_END   = 12'(H_VIS + H_FP + H_SYNC);
    localparam logic [11:0]   VS_BEG   = 12'(V_VIS + V_FP);
    localparam logic [11:0]   VS_END   = 12'(V_VIS + V_FP + V_SYNC);
    localparam logic [11:0]   H_VIS_W  = 12'(H_VIS);
    localparam logic [11:0]   V_VIS_W  = 12'(V_VIS);
    localparam logic          HS_ON    = (H_POL != 0);
    localparam logic          VS_ON    = (V_POL != 0);

    logic [DW-1:0] r_div;
    logic [10:0]   r_hc;
    logic [10:0]   r_vc;
    logic          r_hs;
    logic          r_vs;
    logic          r_de;
    logic [CW-1:0] r_red;
    logic [CW-1:0] r_grn;
    logic [CW-1:0] r_blu;

    logic w_ce;
    logic w_req;
    logic w_hs_act;
    logic w_vs_act;

    // Gated by reset_n so PIX_DIV=1 does not strobe while held in reset
    assign w_ce     = reset_n && (r_div == DIV_LAST);
    assign w_req    = ({1'b0, r_hc} < H_VIS_W) && ({1'b0, r_vc} < V_VIS_W);
    assign w_hs_act = ({1'b0, r_hc} >= HS_BEG) && ({1'b0, r_hc} < HS_END);
    assign w_vs_act = ({1'b0, r_vc} >= VS_BEG) && ({1'b0, r_vc} < VS_END);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (w_ce) begin
            if (r_hc == H_LAST) begin
                r_hc <= '0;
                if (r_vc == V_LAST) begin
                    r_vc <= '0;
                end else begin
                    r_vc <= r_vc + 11'd1;
                end
            end else begin
                r_hc <= r_hc + 11'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hs  <= ~HS_ON;
            r_vs  <= ~VS_ON;
            r_de  <= 1'b0;
            r_red <= '0;
            r_grn <= '0;
            r_blu <= '0;
        end else if (w_ce) begin
            r_hs  <= w_hs_act ? HS_ON : ~HS_ON;
            r_vs  <= w_vs_act ? VS_ON : ~VS_ON;
            r_de  <= w_req;
            r_red <= w_req ? in_r : '0;
            r_grn <= w_req ? in_g : '0;
            r_blu <= w_req ? in_b : '0;
        end
    end

    assign x           = r_hc;
    assign y           = r_vc;
    assign req         = w_req;
    assign pix_ce      = w_ce;
    assign line_start  = w_ce && (r_hc == 11'd0);
    assign frame_start = w_ce && (r_hc == 11'd0) && (r_vc == 11'd0);
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign de          = r_de;
    assign r           = r_red;
    assign g           = r_grn;
    assign b           = r_blu;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: u_a uses default 640x400 timing, u_b a tiny 7x5 raster
// with PIX_DIV=1 and active-high HS for frame-level and vertical checks.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    logic one = 1'b1;

    logic [10:0] a_x, a_y, b_x, b_y;
    logic a_req, a_ce, a_ls, a_fs, a_r, a_g, a_b, a_hs, a_vs, a_de;
    logic b_req, b_ce, b_ls, b_fs, b_r, b_g, b_b, b_hs, b_vs, b_de;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    vga_timing_gen u_a (
        .clock(clk), .reset_n(rst_a), .in_r(one), .in_g(one), .in_b(one),
        .x(a_x), .y(a_y), .req(a_req), .pix_ce(a_ce), .line_start(a_ls),
        .frame_start(a_fs), .r(a_r), .g(a_g), .b(a_b), .hs(a_hs), .vs(a_vs), .de(a_de)
    );

    vga_timing_gen #(
        .H_VIS(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_VIS(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1), .PIX_DIV(1)
    ) u_b (
        .clock(clk), .reset_n(rst_b), .in_r(one), .in_g(one), .in_b(one),
        .x(b_x), .y(b_y), .req(b_req), .pix_ce(b_ce), .line_start(b_ls),
        .frame_start(b_fs), .r(b_r), .g(b_g), .b(b_b), .hs(b_hs), .vs(b_vs), .de(b_de)
    );

    task test_reset;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_x, a_y} !== 22'd0) begin
            errors++; $display("FAIL reset_a_xy: got %0h expected 0", {a_x, a_y});
        end
        checks++;
        if ({a_req, a_ce, a_ls, a_fs, a_hs, a_vs, a_de, a_r, a_g, a_b} !== 10'b1000100000) begin
            errors++; $display("FAIL reset_a_outs: got %b expected 1000100000",
                               {a_req, a_ce, a_ls, a_fs, a_hs, a_vs, a_de, a_r, a_g, a_b});
        end
        checks++;
        if ({b_req, b_ce, b_ls, b_fs, b_hs, b_vs, b_de, b_r, b_g, b_b} !== 10'b1000000000) begin
            errors++; $display("FAIL reset_b_outs: got %b expected 1000000000",
                               {b_req, b_ce, b_ls, b_fs, b_hs, b_vs, b_de, b_r, b_g, b_b});
        end
        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        checks++;
        if ({a_ce, b_ce, b_fs} !== 3'b011) begin
            errors++; $display("FAIL release_ce: got %b expected 011", {a_ce, b_ce, b_fs});
        end
        @(negedge clk);
        checks++;
        if ({a_ce, a_ls, a_fs, a_x} !== {3'b111, 11'd0}) begin
            errors++; $display("FAIL first_strobe_a: got %h expected %h",
                               {a_ce, a_ls, a_fs, a_x}, {3'b111, 11'd0});
        end
        @(negedge clk);
        checks++;
        if ({a_ce, a_x} !== {1'b0, 11'd1}) begin
            errors++; $display("FAIL second_clk_a: got %h expected %h", {a_ce, a_x}, {1'b0, 11'd1});
        end
    endtask

    task test_pix_ce;
        int highs;
        int bad;
        logic prev;
        highs = 0;
        bad = 0;
        prev = a_ce;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_ce) highs++;
            if (a_ce && prev) bad++;
            prev = a_ce;
        end
        checks++;
        if (highs != 10) begin
            errors++; $display("FAIL pix_ce_count: got %0d expected 10", highs);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL pix_ce_adjacent: got %0d expected 0", bad);
        end
    endtask

    task test_line_period;
        int t0;
        int n;
        n = 0;
        while (!a_ls && n < 2000) begin @(negedge clk); n++; end
        t0 = cyc;
        @(negedge clk);
        n = 0;
        while (!a_ls && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (!a_ls || (cyc - t0) != 1600) begin
            errors++; $display("FAIL line_period: got %0d expected 1600", cyc - t0);
        end
    endtask

    task test_hsync;
        int t0;
        int n;
        int strobes;
        int lowlen;
        n = 0;
        while (!a_ls && n < 2000) begin @(negedge clk); n++; end
        t0 = cyc;
        n = 0;
        while (a_hs !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (a_hs !== 1'b0 || (cyc - t0) != 1313) begin
            errors++; $display("FAIL hs_fall: got %0d expected 1313", cyc - t0);
        end
        strobes = 0;
        lowlen = 0;
        while (a_hs === 1'b0 && lowlen < 400) begin
            if (a_ce) strobes++;
            lowlen++;
            @(negedge clk);
        end
        checks++;
        if (strobes != 96) begin
            errors++; $display("FAIL hs_width_strobes: got %0d expected 96", strobes);
        end
        checks++;
        if (lowlen != 192) begin
            errors++; $display("FAIL hs_width_clocks: got %0d expected 192", lowlen);
        end
    endtask

    task test_colour_a;
        int n;
        n = 0;
        while (!(a_x == 11'd640 && a_ce) && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if ({a_de, a_r, a_g, a_b} !== 4'b1111 || a_req !== 1'b0) begin
            errors++; $display("FAIL colour_a_last_vis: got %b expected 11110",
                               {a_de, a_r, a_g, a_b, a_req});
        end
        @(negedge clk);
        checks++;
        if ({a_de, a_r, a_g, a_b} !== 4'b0000 || a_x !== 11'd641) begin
            errors++; $display("FAIL colour_a_blank: got %b x=%0d expected 0000 x=641",
                               {a_de, a_r, a_g, a_b}, a_x);
        end
    endtask

    task test_reset_mid_a;
        int n;
        n = 0;
        while (a_x != 11'd300 && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if ({a_de, a_r} !== 2'b11) begin
            errors++; $display("FAIL mid_a_pre: got %b expected 11", {a_de, a_r});
        end
        #2 rst_a = 1'b0;
        #1;
        checks++;
        if ({a_x, a_y, a_ce, a_ls, a_fs, a_hs, a_vs, a_de, a_r, a_g, a_b} !==
            {22'd0, 9'b000100000}) begin
            errors++; $display("FAIL mid_a_async: got %h expected %h",
                               {a_x, a_y, a_ce, a_ls, a_fs, a_hs, a_vs, a_de, a_r, a_g, a_b},
                               {22'd0, 9'b000100000});
        end
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_fs, a_x, a_y} !== {1'b1, 22'd0}) begin
            errors++; $display("FAIL mid_a_restart: got %h expected %h", {a_fs, a_x, a_y}, {1'b1, 22'd0});
        end
    endtask

    task test_small_periods;
        int t0;
        int n;
        n = 0;
        while (!b_fs && n < 100) begin @(negedge clk); n++; end
        t0 = cyc;
        @(negedge clk);
        n = 0;
        while (!b_fs && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (!b_fs || (cyc - t0) != 35) begin
            errors++; $display("FAIL small_frame_period: got %0d expected 35", cyc - t0);
        end
        @(negedge clk);
        t0 = cyc - 1;
        n = 0;
        while (!b_ls && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (!b_ls || (cyc - t0) != 7) begin
            errors++; $display("FAIL small_line_period: got %0d expected 7", cyc - t0);
        end
    endtask

    task test_small_wrap;
        int n;
        n = 0;
        while (!(b_x == 11'd6 && b_y == 11'd4) && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (b_ce !== 1'b1 || b_x !== 11'd6 || b_y !== 11'd4) begin
            errors++; $display("FAIL wrap_pre: got ce=%b x=%0d y=%0d expected 1 6 4", b_ce, b_x, b_y);
        end
        @(negedge clk);
        checks++;
        if ({b_fs, b_x, b_y} !== {1'b1, 22'd0}) begin
            errors++; $display("FAIL wrap_post: got %h expected %h", {b_fs, b_x, b_y}, {1'b1, 22'd0});
        end
    endtask

    task test_small_frame;
        int n;
        int de_n;
        int vs_n;
        int hs_n;
        int col_bad;
        n = 0;
        while (!b_fs && n < 100) begin @(negedge clk); n++; end
        de_n = 0; vs_n = 0; hs_n = 0; col_bad = 0;
        for (int i = 0; i < 35; i++) begin
            if (b_de) de_n++;
            if (b_vs) vs_n++;
            if (b_hs) hs_n++;
            if ({b_r, b_g, b_b} !== {3{b_de}}) col_bad++;
            @(negedge clk);
        end
        checks++;
        if (de_n != 8) begin
            errors++; $display("FAIL small_de_count: got %0d expected 8", de_n);
        end
        checks++;
        if (vs_n != 7) begin
            errors++; $display("FAIL small_vs_count: got %0d expected 7", vs_n);
        end
        checks++;
        if (hs_n != 5) begin
            errors++; $display("FAIL small_hs_count: got %0d expected 5", hs_n);
        end
        checks++;
        if (col_bad != 0) begin
            errors++; $display("FAIL small_colour_blank: got %0d expected 0", col_bad);
        end
    endtask

    task test_small_colour_edges;
        int n;
        n = 0;
        while (!b_fs && n < 100) begin @(negedge clk); n++; end
        checks++;
        if ({b_req, b_de, b_r} !== 3'b100) begin
            errors++; $display("FAIL edge_x0: got %b expected 100", {b_req, b_de, b_r});
        end
        @(negedge clk);
        checks++;
        if ({b_x, b_de, b_r} !== {11'd1, 2'b11}) begin
            errors++; $display("FAIL edge_x1: got %h expected %h", {b_x, b_de, b_r}, {11'd1, 2'b11});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({b_x, b_req, b_de, b_r} !== {11'd4, 3'b011}) begin
            errors++; $display("FAIL edge_x4: got %h expected %h", {b_x, b_req, b_de, b_r}, {11'd4, 3'b011});
        end
        @(negedge clk);
        checks++;
        if ({b_de, b_r, b_hs} !== 3'b000) begin
            errors++; $display("FAIL edge_x5: got %b expected 000", {b_de, b_r, b_hs});
        end
        @(negedge clk);
        checks++;
        if ({b_x, b_hs} !== {11'd6, 1'b1}) begin
            errors++; $display("FAIL edge_hs: got %h expected %h", {b_x, b_hs}, {11'd6, 1'b1});
        end
    endtask

    task test_reset_mid_b;
        int n;
        n = 0;
        while (!(b_x == 11'd3 && b_y == 11'd1) && n < 100) begin @(negedge clk); n++; end
        checks++;
        if ({b_de, b_r} !== 2'b11) begin
            errors++; $display("FAIL mid_b_pre: got %b expected 11", {b_de, b_r});
        end
        #2 rst_b = 1'b0;
        #1;
        checks++;
        if ({b_x, b_y, b_ce, b_ls, b_fs, b_hs, b_vs, b_de, b_r, b_g, b_b} !== 31'd0) begin
            errors++; $display("FAIL mid_b_async: got %h expected 0",
                               {b_x, b_y, b_ce, b_ls, b_fs, b_hs, b_vs, b_de, b_r, b_g, b_b});
        end
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        checks++;
        if ({b_ce, b_fs, b_x, b_y} !== {2'b11, 22'd0}) begin
            errors++; $display("FAIL mid_b_restart: got %h expected %h", {b_ce, b_fs, b_x, b_y}, {2'b11, 22'd0});
        end
        @(negedge clk);
        checks++;
        if ({b_x, b_y, b_de} !== {11'd1, 11'd0, 1'b1}) begin
            errors++; $display("FAIL mid_b_advance: got %h expected %h", {b_x, b_y, b_de}, {11'd1, 11'd0, 1'b1});
        end
    endtask

    initial begin
        test_reset;
        test_pix_ce;
        test_line_period;
        test_hsync;
        test_colour_a;
        test_reset_mid_a;
        test_small_periods;
        test_small_wrap;
        test_small_frame;
        test_small_colour_edges;
        test_reset_mid_b;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
